// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package mult_div_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_e;

   // Booth recode of {multiplier bit, previous bit}
   localparam logic [1:0] BOOTH_NONE_LO = 2'b00;
   localparam logic [1:0] BOOTH_ADD     = 2'b01;
   localparam logic [1:0] BOOTH_SUB     = 2'b10;
   localparam logic [1:0] BOOTH_NONE_HI = 2'b11;

endpackage

// File: rtl/mult_div_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor always, so the WIDTH+1 bit difference never wraps and its MSB is the borrow
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      if (diff[WIDTH]) begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end else begin
         rem_out = diff[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mult_div.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
module mult_div
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init_mult,
   input  logic             init_div,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // mult: product high half; div: remainder
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // mult: multiplier/product low; div: quotient
   logic               acc_q1_q, acc_q1_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               div_zero_q, div_zero_d;

   logic [WIDTH:0]     booth_sum;
   logic [WIDTH-1:0]   step_rem, step_quo;
   logic               last;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc_hi_q),
      .quo_in  (acc_lo_q),
      .divisor (opnd_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   assign last = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      acc_q1_d   = acc_q1_q;
      opnd_d     = opnd_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      booth_sum  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (init_mult) begin
               state_d    = S_MULT;
               cnt_d      = '0;
               acc_hi_d   = '0;
               acc_lo_d   = b_in;
               acc_q1_d   = 1'b0;
               opnd_d     = a_in;
               div_zero_d = 1'b0;
            end else if (init_div) begin
               cnt_d      = '0;
               div_zero_d = (b_in == '0);
               if (b_in == '0) begin
                  state_d = S_FIN;
               end else begin
                  state_d   = S_DIV;
                  acc_hi_d  = '0;
                  acc_lo_d  = a_in[WIDTH-1] ? -a_in : a_in;
                  opnd_d    = b_in[WIDTH-1] ? -b_in : b_in;
                  neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                  neg_rem_d = a_in[WIDTH-1];
               end
            end
         end

         S_MULT: begin
            // One guard bit keeps hi -/+ 0x8000_0000 from overflowing before the shift
            unique case ({acc_lo_q[0], acc_q1_q})
               BOOTH_ADD: booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} + {opnd_q[WIDTH-1], opnd_q};
               BOOTH_SUB: booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} - {opnd_q[WIDTH-1], opnd_q};
               BOOTH_NONE_LO, BOOTH_NONE_HI: booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q};
            endcase
            acc_hi_d = booth_sum[WIDTH:1];
            acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
            acc_q1_d = acc_lo_q[0];
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
               state_d = S_FIN;
               hi_d    = acc_hi_d;
               lo_d    = acc_lo_d;
            end
         end

         S_DIV: begin
            acc_hi_d = step_rem;
            acc_lo_d = step_quo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
               state_d = S_FIN;
               hi_d    = neg_rem_q ? -step_rem : step_rem;
               lo_d    = neg_quo_q ? -step_quo : step_quo;
            end
         end

         S_FIN: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         acc_q1_q   <= 1'b0;
         opnd_q     <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         acc_q1_q   <= acc_q1_d;
         opnd_q     <= opnd_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign busy     = (state_q == S_MULT) || (state_q == S_DIV);
   assign done     = (state_q == S_FIN);
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed, table-driven bench for mult_div plus hand-written multi-cycle corner sequences.
module tb_mult_div;

   logic        clk;
   logic        reset;
   logic        init_mult;
   logic        init_div;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   int n_checks = 0;
   int n_pass   = 0;

   mult_div dut (
      .clk       (clk),
      .reset     (reset),
      .init_mult (init_mult),
      .init_div  (init_div),
      .a_in      (a_in),
      .b_in      (b_in),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic        is_mult;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dz;
      int          exp_cycles;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Pulses the start for one edge, scrambles operands afterwards and waits for done
   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit busy_seen);
      @(negedge clk);
      a_in = a; b_in = b; init_mult = m; init_div = d;
      @(negedge clk);
      init_mult = 1'b0; init_div = 1'b0;
      a_in = $urandom; b_in = $urandom;
      cyc = 0;
      busy_seen = 1'b0;
      while (!done && cyc < 60) begin
         busy_seen |= busy;
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      bit bsy;
      int done_cnt;
      int done_at;
      logic [31:0] cap_hi, cap_lo;

      vecs[0] = '{"mul_m7x3",   1'b1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32};
      vecs[1] = '{"mul_min2",   1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32};
      vecs[2] = '{"mul_m1xm1",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32};
      vecs[3] = '{"mul_neg",    1'b1, 32'h00012345, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFC9631, 1'b0, 32};
      vecs[4] = '{"div_m7d2",   1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
      vecs[5] = '{"div_7dm2",   1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
      vecs[6] = '{"div_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
      vecs[7] = '{"div_100d7",  1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 32};
      vecs[8] = '{"div_5d2",    1'b0, 32'h00000005, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0, 32};

      reset = 1'b0; init_mult = 1'b0; init_div = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      check("reset_hilo",  {hi_out, lo_out}, 64'h0);
      check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b, cyc, bsy);
         check({vecs[i].name, "_cycles"}, 64'(cyc), 64'(vecs[i].exp_cycles));
         check({vecs[i].name, "_hi"}, 64'(hi_out), 64'(vecs[i].exp_hi));
         check({vecs[i].name, "_lo"}, 64'(lo_out), 64'(vecs[i].exp_lo));
         check({vecs[i].name, "_flags"}, {61'h0, bsy, busy, div_zero}, {61'h0, 1'b1, 1'b0, vecs[i].exp_dz});
         @(negedge clk);
         check({vecs[i].name, "_done_1cyc"}, {62'h0, done, busy}, 64'h0);
      end

      // Divide by zero right after 5/2 left hi=1, lo=2
      run_op(1'b0, 1'b1, 32'h00000009, 32'h00000000, cyc, bsy);
      check("dz_cycles", 64'(cyc), 64'd0);
      check("dz_flags", {61'h0, done, div_zero, busy}, {61'h0, 1'b1, 1'b1, 1'b0});
      check("dz_hilo", {hi_out, lo_out}, {32'h1, 32'h2});
      @(negedge clk);
      check("dz_after", {61'h0, done, busy, div_zero}, {61'h0, 1'b0, 1'b0, 1'b1});

      // Reset in the middle of a multiply
      a_in = 32'd123; b_in = 32'd456; init_mult = 1'b1;
      @(negedge clk);
      init_mult = 1'b0;
      check("abort_div_zero_cleared", {63'h0, div_zero}, 64'h0);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_hilo", {hi_out, lo_out}, 64'h0);
      check("abort_flags", {61'h0, busy, done, div_zero}, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      done_cnt = 0;
      bsy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
         bsy |= busy;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_no_busy", {63'h0, bsy}, 64'h0);
      run_op(1'b1, 1'b0, 32'd6, 32'd7, cyc, bsy);
      check("post_abort_cycles", 64'(cyc), 64'd32);
      check("post_abort_hilo", {hi_out, lo_out}, {32'h0, 32'd42});

      // init_div pulsed during a multiply must be ignored
      @(negedge clk);
      @(negedge clk);
      a_in = 32'h00012345; b_in = 32'hFFFFFFFD; init_mult = 1'b1;
      @(negedge clk);
      init_mult = 1'b0;
      done_cnt = 0;
      done_at = -1;
      cap_hi = '0; cap_lo = '0;
      for (int i = 0; i < 45; i++) begin
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = i;
               cap_hi = hi_out;
               cap_lo = lo_out;
            end
         end
         if (i == 5) begin
            init_div = 1'b1; a_in = 32'd100; b_in = 32'd7;
         end else begin
            init_div = 1'b0;
         end
         @(negedge clk);
      end
      check("ignored_done_count", 64'(done_cnt), 64'd1);
      check("ignored_done_at", 64'(done_at), 64'd32);
      check("ignored_hilo", {cap_hi, cap_lo}, {32'hFFFFFFFF, 32'hFFFC9631});

      // Simultaneous starts in IDLE: multiply wins
      run_op(1'b1, 1'b1, 32'd4, 32'd2, cyc, bsy);
      check("both_cycles", 64'(cyc), 64'd32);
      check("both_hilo", {hi_out, lo_out}, {32'h0, 32'd8});
      check("both_dz", {63'h0, div_zero}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
